// File: rtl/vga_tile_scanout.sv
// vga_tile_scanout: VGA timing generator and tile-map scanout for the video RAM.
// Stage A (_p0) holds the pixel counters and drives the RAM address; stage B (_p1)
// registers colour, syncs and the visible flag one pixel period later, so that
// the registered RAM read has settled by the time stage B captures it.
module vga_tile_scanout #(
    parameter int PIX_DIV = 2,
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int H_SW    = 96,
    parameter int H_BP    = 48,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10,
    parameter int V_SW    = 2,
    parameter int V_BP    = 33
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iEnable,
    input  logic [4:0] iScrollX,
    output logic [9:0] oReadAddress,
    input  logic [2:0] iReadData,
    output logic       oRed,
    output logic       oGreen,
    output logic       oBlue,
    output logic       oHSync,
    output logic       oVSync,
    output logic [9:0] oColumnCount,
    output logic [9:0] oRowCount,
    output logic       oVisible,
    output logic       oFrameStart
);

    localparam int H_TOT = H_VIS + H_FP + H_SW + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SW + V_BP;
    localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic [9:0] COL_LAST = 10'(H_TOT - 1);
    localparam logic [9:0] ROW_LAST = 10'(V_TOT - 1);
    localparam logic [9:0] COL_VIS  = 10'(H_VIS);
    localparam logic [9:0] ROW_VIS  = 10'(V_VIS);
    localparam logic [9:0] HS_FIRST = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_VIS + H_FP + H_SW - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_VIS + V_FP + V_SW - 1);

    // Tile column plus scroll offset; the 32-column map wraps around mod 32.
    function automatic logic [4:0] wrap_tile_col(input logic [4:0] col_tile,
                                                 input logic [4:0] scroll);
        return col_tile + scroll;
    endfunction

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       col_p0_q, col_p0_d;
    logic [9:0]       row_p0_q, row_p0_d;
    logic [4:0]       scroll_p0_q, scroll_p0_d;
    logic             frame_start_q, frame_start_d;
    logic [2:0]       rgb_p1_q, rgb_p1_d;
    logic             hsync_p1_q, hsync_p1_d;
    logic             vsync_p1_q, vsync_p1_d;
    logic             vld_p1_q, vld_p1_d;

    logic tick;
    logic col_last;
    logic row_last;
    logic frame_wrap;
    logic vld_p0;
    logic hsync_p0;
    logic vsync_p0;

    // Next-state logic: pixel divider, stage-A counters, frame-locked scroll, stage-B capture.
    always_comb begin
        tick       = (div_q == DIV_LAST) && iEnable;
        col_last   = (col_p0_q == COL_LAST);
        row_last   = (row_p0_q == ROW_LAST);
        frame_wrap = tick && col_last && row_last;

        vld_p0   = (col_p0_q < COL_VIS) && (row_p0_q < ROW_VIS);
        hsync_p0 = ~((col_p0_q >= HS_FIRST) && (col_p0_q <= HS_LAST));
        vsync_p0 = ~((row_p0_q >= VS_FIRST) && (row_p0_q <= VS_LAST));

        div_d = div_q;
        if (iEnable) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        end

        // stage A: raster position of the pixel currently being fetched
        col_p0_d    = col_p0_q;
        row_p0_d    = row_p0_q;
        scroll_p0_d = scroll_p0_q;
        if (tick) begin
            if (col_last) begin
                col_p0_d = '0;
                row_p0_d = row_last ? '0 : row_p0_q + 10'd1;
            end else begin
                col_p0_d = col_p0_q + 10'd1;
            end
        end
        if (frame_wrap) begin
            scroll_p0_d = iScrollX;
        end
        frame_start_d = frame_wrap;

        // stage B: the previous stage-A pixel, with its RAM data now valid
        rgb_p1_d   = rgb_p1_q;
        hsync_p1_d = hsync_p1_q;
        vsync_p1_d = vsync_p1_q;
        vld_p1_d   = vld_p1_q;
        if (tick) begin
            rgb_p1_d   = vld_p0 ? iReadData : 3'b000;
            hsync_p1_d = hsync_p0;
            vsync_p1_d = vsync_p0;
            vld_p1_d   = vld_p0;
        end
    end

    // State registers; asynchronous reset restarts the raster at (0,0) with syncs idle.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            div_q         <= '0;
            col_p0_q      <= '0;
            row_p0_q      <= '0;
            scroll_p0_q   <= '0;
            frame_start_q <= 1'b0;
            rgb_p1_q      <= 3'b000;
            hsync_p1_q    <= 1'b1;
            vsync_p1_q    <= 1'b1;
            vld_p1_q      <= 1'b0;
        end else begin
            div_q         <= div_d;
            col_p0_q      <= col_p0_d;
            row_p0_q      <= row_p0_d;
            scroll_p0_q   <= scroll_p0_d;
            frame_start_q <= frame_start_d;
            rgb_p1_q      <= rgb_p1_d;
            hsync_p1_q    <= hsync_p1_d;
            vsync_p1_q    <= vsync_p1_d;
            vld_p1_q      <= vld_p1_d;
        end
    end

    assign oReadAddress = {row_p0_q[8:4], wrap_tile_col(col_p0_q[9:5], scroll_p0_q)};
    assign oColumnCount = col_p0_q;
    assign oRowCount    = row_p0_q;
    assign oRed         = rgb_p1_q[2];
    assign oGreen       = rgb_p1_q[1];
    assign oBlue        = rgb_p1_q[0];
    assign oHSync       = hsync_p1_q;
    assign oVSync       = vsync_p1_q;
    assign oVisible     = vld_p1_q;
    assign oFrameStart  = frame_start_q;

endmodule
